// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported data memory.
// One access outstanding at a time: IDLE -> ACCESS (ACC_CYCLES) -> RESP.
module data_mem_arbiter #(
   parameter int unsigned ACC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_valid,
   input  logic        p1_valid,
   input  logic        p0_write,
   input  logic        p1_write,
   input  logic [8:0]  p0_addr,
   input  logic [8:0]  p1_addr,
   input  logic [31:0] p0_wdata,
   input  logic [31:0] p1_wdata,
   output logic        p0_ready,
   output logic        p1_ready,
   output logic        p0_rvalid,
   output logic        p1_rvalid,
   output logic [31:0] p0_rdata,
   output logic [31:0] p1_rdata,
   output logic        p0_err,
   output logic        p1_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [8:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        write_q, write_d;
   logic        err_q, err_d;
   logic [8:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        idle_ok, gnt0, gnt1;
   logic        in_acc, in_resp;
   logic [8:0]  sel_addr;

   // last_q = 1 means requester 1 was served last, so requester 0 wins a tie
   assign idle_ok  = ~rst & (state_q == IDLE);
   assign gnt0     = idle_ok & p0_valid & (~p1_valid | last_q);
   assign gnt1     = idle_ok & p1_valid & ~gnt0;
   assign sel_addr = gnt1 ? p1_addr : p0_addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      write_d = write_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (gnt0 | gnt1) begin
               owner_d = gnt1;
               write_d = gnt1 ? p1_write : p0_write;
               addr_d  = sel_addr;
               wdata_d = gnt1 ? p1_wdata : p0_wdata;
               rdata_d = '0;
               err_d   = |sel_addr[1:0];
               cnt_d   = CNT_INIT;
               state_d = (|sel_addr[1:0]) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               if (!write_q) rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         write_q <= write_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode the async-reset state, so they drop the moment rst rises
   assign in_acc    = (state_q == ACCESS);
   assign in_resp   = (state_q == RESP);
   assign MemRead   = in_acc & ~write_q;
   assign MemWrite  = in_acc & write_q;
   assign mem_addr  = in_acc ? addr_q : '0;
   assign mem_wdata = in_acc ? wdata_q : '0;

   assign p0_ready  = gnt0;
   assign p1_ready  = gnt1;
   assign p0_rvalid = in_resp & ~owner_q;
   assign p1_rvalid = in_resp & owner_q;
   assign p0_err    = p0_rvalid & err_q;
   assign p1_err    = p1_rvalid & err_q;
   assign p0_rdata  = p0_rvalid ? rdata_q : '0;
   assign p1_rdata  = p1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: instance 0 with ACC_CYCLES=1, instance 1 with 3.
// Stimulus pushes expected responses; negedge monitors pop and compare.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst;
   logic [1:0]        pre;
   logic [3:0]        v, w;
   logic [3:0][8:0]   a;
   logic [3:0][31:0]  d;
   wire  [3:0]        rdy, rv, er;
   wire  [3:0][31:0]  rd;
   wire  [1:0]        mrd, mwr;
   wire  [1:0][8:0]   maddr;
   wire  [1:0][31:0]  mwd, mrdat;

   typedef struct {
      int          k;
      int          p;
      logic [31:0] rd;
      logic        er;
      int          cyc;
      int          str;
   } exp_t;

   exp_t        q[$];
   int          gl[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          str_cnt[2];
   logic [8:0]  ea[2];
   logic        ew[2];
   logic [31:0] ewd[2];
   logic [3:0]  armed;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int k, input int p);
      exp_t e;
      int   i;
      i = k * 2 + p;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_rvalid inst%0d p%0d cyc=%0d", k, p, cyc);
      end else begin
         e = q.pop_front();
         if (e.k != k || e.p != p || e.rd != rd[i] || e.er != er[i] ||
             e.cyc != cyc || e.str != str_cnt[k]) begin
            errors++;
            $display("FAIL resp inst%0d p%0d got rdata=%h err=%b cyc=%0d strobes=%0d want inst%0d p%0d rdata=%h err=%b cyc=%0d strobes=%0d",
                     k, p, rd[i], er[i], cyc, str_cnt[k],
                     e.k, e.p, e.rd, e.er, e.cyc, e.str);
         end
      end
      str_cnt[k] = 0;
   endtask

   task automatic chk_zero(input int k, input string tag);
      checks++;
      if (rdy[2*k +: 2] != 2'b00 || rv[2*k +: 2] != 2'b00 ||
          er[2*k +: 2] != 2'b00 || rd[2*k] != 32'd0 || rd[2*k+1] != 32'd0 ||
          mrd[k] || mwr[k] || maddr[k] != 9'd0 || mwd[k] != 32'd0) begin
         errors++;
         $display("FAIL %s inst%0d outputs not zero: rdy=%b rv=%b err=%b rd0=%h rd1=%h rd=%b wr=%b addr=%h wd=%h, want all 0",
                  tag, k, rdy[2*k +: 2], rv[2*k +: 2], er[2*k +: 2],
                  rd[2*k], rd[2*k+1], mrd[k], mwr[k], maddr[k], mwd[k]);
      end
   endtask

   genvar g;
   for (g = 0; g < 2; g++) begin : gi
      logic [31:0] mem [128];

      data_mem_arbiter #(.ACC_CYCLES(g == 0 ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst       (rst[g]),
         .p0_valid  (v[2*g]),
         .p1_valid  (v[2*g+1]),
         .p0_write  (w[2*g]),
         .p1_write  (w[2*g+1]),
         .p0_addr   (a[2*g]),
         .p1_addr   (a[2*g+1]),
         .p0_wdata  (d[2*g]),
         .p1_wdata  (d[2*g+1]),
         .p0_ready  (rdy[2*g]),
         .p1_ready  (rdy[2*g+1]),
         .p0_rvalid (rv[2*g]),
         .p1_rvalid (rv[2*g+1]),
         .p0_rdata  (rd[2*g]),
         .p1_rdata  (rd[2*g+1]),
         .p0_err    (er[2*g]),
         .p1_err    (er[2*g+1]),
         .MemRead   (mrd[g]),
         .MemWrite  (mwr[g]),
         .mem_addr  (maddr[g]),
         .mem_wdata (mwd[g]),
         .mem_rdata (mrdat[g])
      );

      always @(posedge clk) begin
         if (pre[g]) mem[127] <= 32'h12345678;
         else if (mwr[g]) mem[maddr[g][8:2]] <= mwd[g];
      end
      assign mrdat[g] = mem[maddr[g][8:2]];

      always @(negedge clk) begin
         checks++;
         if (mrd[g] | mwr[g]) begin
            str_cnt[g]++;
            if (maddr[g] != ea[g] || mwd[g] != ewd[g] ||
                mwr[g] != ew[g] || mrd[g] == mwr[g]) begin
               errors++;
               $display("FAIL strobe inst%0d got rd=%b wr=%b addr=%h wd=%h want wr=%b addr=%h wd=%h",
                        g, mrd[g], mwr[g], maddr[g], mwd[g], ew[g], ea[g], ewd[g]);
            end
         end else if (maddr[g] != 9'd0 || mwd[g] != 32'd0) begin
            errors++;
            $display("FAIL mem_idle inst%0d got addr=%h wd=%h want 0", g, maddr[g], mwd[g]);
         end
         checks++;
         if (rdy[2*g] && rdy[2*g+1]) begin
            errors++;
            $display("FAIL both_ready inst%0d got 11 want at most one", g);
         end
         for (int p = 0; p < 2; p++) begin
            if (rdy[2*g+p]) begin
               checks++;
               if (!armed[2*g+p]) begin
                  errors++;
                  $display("FAIL stray_ready inst%0d p%0d got 1 want 0", g, p);
               end
            end
            if (rv[2*g+p]) chk(g, p);
            else begin
               checks++;
               if (er[2*g+p] || rd[2*g+p] != 32'd0) begin
                  errors++;
                  $display("FAIL idle_resp inst%0d p%0d got err=%b rdata=%h want 0",
                           g, p, er[2*g+p], rd[2*g+p]);
               end
            end
         end
      end
   end

   task automatic req(input int k, input int p, input logic wr,
                      input logic [8:0] ad, input logic [31:0] wd,
                      input logic [31:0] erd, input bit resp);
      int   i;
      int   acc;
      bit   got;
      exp_t e;
      i   = k * 2 + p;
      acc = (k == 0) ? 1 : 3;
      got = 0;
      @(posedge clk);
      #1;
      v[i] = 1'b1; w[i] = wr; a[i] = ad; d[i] = wd; armed[i] = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (rdy[i]) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ready_timeout inst%0d p%0d got none want ready", k, p);
      end else begin
         gl.push_back(i);
         ea[k] = ad; ew[k] = wr; ewd[k] = wd;
         if (resp) begin
            e.k   = k;
            e.p   = p;
            e.er  = (ad[1:0] != 2'b00);
            e.rd  = e.er ? 32'd0 : erd;
            e.cyc = cyc + (e.er ? 1 : acc + 1);
            e.str = e.er ? 0 : acc;
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      v[i] = 1'b0; armed[i] = 1'b0;
   endtask

   task automatic chk_gl(input int idx, input int want);
      checks++;
      if (gl.size() <= idx || gl[idx] != want) begin
         errors++;
         $display("FAIL grant_order idx%0d got %0d want %0d", idx,
                  (gl.size() > idx) ? gl[idx] : -1, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 2'b11; pre = 2'b00; v = '0; w = '0; a = '0; d = '0;
      armed = '0; str_cnt[0] = 0; str_cnt[1] = 0;
      ea[0] = '0; ea[1] = '0; ew[0] = 0; ew[1] = 0; ewd[0] = '0; ewd[1] = '0;
      @(posedge clk);
      #1;
      v = 4'b1111; pre = 2'b10;
      @(posedge clk);
      #1;
      pre = 2'b00;
      chk_zero(0, "reset");
      chk_zero(1, "reset");
      v = 4'b0000;
      @(negedge clk);
      rst = 2'b00;

      // ACC_CYCLES=1: write then read back, misaligned cases
      req(0, 0, 1, 9'h010, 32'hDEADBEEF, 32'h0, 1);
      req(0, 0, 0, 9'h010, 32'h0, 32'hDEADBEEF, 1);
      req(0, 1, 0, 9'h006, 32'h0, 32'h0, 1);
      req(0, 0, 1, 9'h011, 32'h00000055, 32'h0, 1);
      req(0, 1, 0, 9'h010, 32'h0, 32'hDEADBEEF, 1);
      // p0 raises valid only while the arbiter is busy, then withdraws
      v[0] = 1'b1; w[0] = 1'b0; a[0] = 9'h010;
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      repeat (3) @(posedge clk);

      // both valid continuously: grants must alternate starting with p0
      gl.delete();
      fork
         begin
            req(0, 0, 1, 9'h020, 32'hA5A5A5A5, 32'h0, 1);
            req(0, 0, 0, 9'h024, 32'h0, 32'h3C3C3C3C, 1);
         end
         begin
            req(0, 1, 1, 9'h024, 32'h3C3C3C3C, 32'h0, 1);
            req(0, 1, 0, 9'h020, 32'h0, 32'hA5A5A5A5, 1);
         end
      join
      chk_gl(0, 0);
      chk_gl(1, 1);
      chk_gl(2, 0);
      chk_gl(3, 1);

      // ACC_CYCLES=3
      req(1, 1, 0, 9'h1FC, 32'h0, 32'h12345678, 1);
      req(1, 0, 1, 9'h100, 32'hCAFEF00D, 32'h0, 1);
      req(1, 1, 0, 9'h100, 32'h0, 32'hCAFEF00D, 1);
      req(1, 0, 0, 9'h100, 32'h0, 32'hCAFEF00D, 1);
      repeat (2) @(posedge clk);

      // reset in the second ACCESS cycle of a p0 write
      req(1, 0, 1, 9'h040, 32'h11112222, 32'h0, 0);
      @(posedge clk);
      #2;
      checks++;
      if (!mwr[1]) begin
         errors++;
         $display("FAIL pre_rst_strobe got MemWrite=0 want 1");
      end
      #1;
      rst[1] = 1'b1;
      #1;
      chk_zero(1, "mid_rst");
      @(negedge clk);
      str_cnt[1] = 0;
      rst[1] = 1'b0;
      gl.delete();
      fork
         req(1, 0, 0, 9'h1FC, 32'h0, 32'h12345678, 1);
         req(1, 1, 0, 9'h100, 32'h0, 32'hCAFEF00D, 1);
      join
      chk_gl(0, 2);
      chk_gl(1, 3);

      for (int n = 0; n < 50 && q.size() > 0; n++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ACC_CYCLES, default 1, number of cycles MemRead/MemWrite stay asserted per access (legal 1-15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 p0_valid, p1_valid  input  1 each  requester n has a pending access.
REQ-005 p0_write, p1_write  input  1 each  1 = write, 0 = read.
REQ-006 p0_addr, p1_addr  input  9 each  byte address; word index = addr[8:2].
REQ-007 p0_wdata, p1_wdata  input  32 each  write data.
REQ-008 p0_ready, p1_ready  output  1 each  one-cycle accept pulse; request fields sampled this cycle.
REQ-009 p0_rvalid, p1_rvalid  output  1 each  one-cycle completion pulse.
REQ-010 p0_rdata, p1_rdata  output  32 each  read data, valid with rvalid; 0 for writes and errors.
REQ-011 p0_err, p1_err  output  1 each  misaligned-address flag, valid with rvalid.
REQ-012 MemRead, MemWrite  output  1 each  data memory strobes.
REQ-013 mem_addr  output  9  data memory address.
REQ-014 mem_wdata  output  32  data memory write data.
REQ-015 mem_rdata  input  32  data memory read data (combinational from memory).

Function
REQ-016 FSM states IDLE, ACCESS, RESP; exactly one access outstanding at a time.
REQ-017 IDLE: if any valid, winner chosen combinationally, its ready pulsed that cycle, addr/write/wdata/owner latched, next state ACCESS (aligned) or RESP (addr[1:0] != 0).
REQ-018 Arbitration round-robin: sole requester wins; both valid -> requester not granted last wins.
REQ-019 ACCESS: MemRead = ~write_l, MemWrite = write_l, asserted every ACCESS cycle, deasserted in IDLE and RESP.
REQ-020 mem_addr and mem_wdata equal latched values and are stable for all ACCESS cycles; 0 outside ACCESS.
REQ-021 ACCESS lasts exactly ACC_CYCLES cycles via down-counter; on final cycle mem_rdata captured (reads only), next state RESP.
REQ-022 RESP: owner's rvalid = 1 for one cycle with captured rdata, err = 0; next state IDLE; last-grant updated to owner.
REQ-023 Misaligned request: no memory strobe ever asserted; RESP pulses rvalid with err = 1, rdata = 0.
REQ-024 Latency: ready at cycle T -> rvalid at T+ACC_CYCLES+1 (aligned), T+1 (misaligned).
REQ-025 New grant earliest in cycle after RESP; requests during ACCESS/RESP are not accepted and not lost (requester holds valid).
REQ-026 Non-owner rvalid/err stay 0; rdata of non-owner holds 0.
REQ-027 Requester dropping valid before ready: no access, no response.
REQ-028 Write followed by read of same word by any requester returns written data.

Reset
REQ-029 rst asserted: state IDLE, counter 0, all outputs 0, captured data 0, last-grant = requester 1 (requester 0 wins first tie).
REQ-030 rst mid-ACCESS: strobes drop immediately (asynchronously), no rvalid issued for aborted access; memory content after aborted write unspecified.
REQ-031 After rst deasserts, first grant possible on first rising edge.

Verification
REQ-032 ACC_CYCLES=1; p0 write addr 0x010 data 0xDEADBEEF, then p0 read 0x010 -> MemWrite high 1 cycle with mem_addr 0x010; read rvalid with rdata 0xDEADBEEF 2 cycles after ready.
REQ-033 p0 and p1 both valid continuously after reset -> grants alternate p0, p1, p0, p1; no cycle with both ready.
REQ-034 p1 read addr 0x006 -> p1_rvalid next cycle, p1_err = 1, p1_rdata = 0, MemRead/MemWrite never asserted.
REQ-035 ACC_CYCLES=3; p1 read 0x1FC after memory preloaded 0x12345678 -> MemRead high 3 cycles, mem_addr stable 0x1FC, p1_rvalid 4 cycles after ready, rdata 0x12345678.
REQ-036 rst pulsed during second ACCESS cycle of a p0 write (ACC_CYCLES=3) -> MemWrite low same time as rst, no p0_rvalid, all outputs 0, next both-valid tie granted to p0.
